// File: rtl/rob_pkg.sv
// Shared sizing defaults and the per-entry record for the reorder buffer.
package rob_pkg;

    localparam int NUM_ENTRIES       = 8;
    localparam int LOG_NUM_ENTRIES   = 3;
    localparam int LOG_NUM_REGISTERS = 3;
    localparam int DATA_WIDTH        = 16;

    typedef struct packed {
        logic                         valid;
        logic                         done;
        logic                         exception;
        logic [LOG_NUM_REGISTERS-1:0] dest;
        logic [DATA_WIDTH-1:0]        data;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry.sv
// One reorder-buffer slot: allocation, writeback capture and retirement.
module rob_entry
    import rob_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         alloc,
    input  logic [LOG_NUM_REGISTERS-1:0] alloc_dest,
    input  logic                         wb,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         wb_exception,
    input  logic                         retire,
    output rob_entry_t                   entry
);

    // Clear outranks everything; a writeback only lands on an occupied slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else begin
            if (alloc) begin
                entry.valid     <= 1'b1;
                entry.done      <= 1'b0;
                entry.exception <= 1'b0;
                entry.dest      <= alloc_dest;
            end else if (wb && entry.valid) begin
                entry.done      <= 1'b1;
                entry.data      <= wb_data;
                entry.exception <= wb_exception;
            end
            if (retire) begin
                entry.valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with out-of-order writeback and operand bypass.
module reorder_buffer #(
    parameter int NUM_ENTRIES       = rob_pkg::NUM_ENTRIES,
    parameter int LOG_NUM_ENTRIES   = rob_pkg::LOG_NUM_ENTRIES,
    parameter int LOG_NUM_REGISTERS = rob_pkg::LOG_NUM_REGISTERS,
    parameter int DATA_WIDTH        = rob_pkg::DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         alloc_valid,
    input  logic [LOG_NUM_REGISTERS-1:0] alloc_dest,
    output logic                         alloc_ready,
    output logic [LOG_NUM_ENTRIES-1:0]   alloc_tag,
    input  logic                         wb_valid,
    input  logic [LOG_NUM_ENTRIES-1:0]   wb_tag,
    input  logic [DATA_WIDTH-1:0]        wb_data,
    input  logic                         wb_exception,
    input  logic [LOG_NUM_ENTRIES-1:0]   rd_tag_a,
    input  logic [LOG_NUM_ENTRIES-1:0]   rd_tag_b,
    output logic                         rd_ready_a,
    output logic                         rd_ready_b,
    output logic [DATA_WIDTH-1:0]        rd_data_a,
    output logic [DATA_WIDTH-1:0]        rd_data_b,
    output logic                         commit_valid,
    input  logic                         commit_ready,
    output logic [LOG_NUM_REGISTERS-1:0] commit_dest,
    output logic [DATA_WIDTH-1:0]        commit_data,
    output logic                         commit_exception,
    input  logic                         flush,
    output logic [LOG_NUM_ENTRIES:0]     count
);

    localparam logic [LOG_NUM_ENTRIES:0] FULL_COUNT = (LOG_NUM_ENTRIES+1)'(NUM_ENTRIES);

    rob_pkg::rob_entry_t        entries [NUM_ENTRIES];
    rob_pkg::rob_entry_t        head_entry;
    logic [LOG_NUM_ENTRIES-1:0] head;
    logic [LOG_NUM_ENTRIES-1:0] tail;
    logic                       do_alloc;
    logic                       do_commit;
    logic                       clear_all;

    assign head_entry       = entries[head];
    assign alloc_ready      = (count != FULL_COUNT);
    assign alloc_tag        = tail;
    assign commit_valid     = head_entry.valid && head_entry.done;
    assign commit_dest      = head_entry.dest;
    assign commit_data      = head_entry.data;
    assign commit_exception = head_entry.exception;

    assign do_alloc  = alloc_valid && alloc_ready && !flush;
    assign do_commit = commit_valid && commit_ready && !flush;
    // Retiring a faulting instruction squashes everything younger, including this cycle's allocation.
    assign clear_all = flush || (do_commit && head_entry.exception);

    generate
        for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_entry
            rob_entry u_entry (
                .clk          (clk),
                .reset        (reset),
                .clear        (clear_all),
                .alloc        (do_alloc && (tail == LOG_NUM_ENTRIES'(i))),
                .alloc_dest   (alloc_dest),
                .wb           (wb_valid && (wb_tag == LOG_NUM_ENTRIES'(i))),
                .wb_data      (wb_data),
                .wb_exception (wb_exception),
                .retire       (do_commit && (head == LOG_NUM_ENTRIES'(i))),
                .entry        (entries[i])
            );
        end
    endgenerate

    // Pointers wrap naturally because NUM_ENTRIES is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear_all) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_alloc) begin
                tail <= tail + 1'b1;
            end
            if (do_commit) begin
                head <= head + 1'b1;
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Lookups see a same-cycle writeback so consumers need not wait a cycle.
    always_comb begin
        rd_ready_a = entries[rd_tag_a].valid && entries[rd_tag_a].done;
        rd_data_a  = entries[rd_tag_a].data;
        rd_ready_b = entries[rd_tag_b].valid && entries[rd_tag_b].done;
        rd_data_b  = entries[rd_tag_b].data;
        if (wb_valid && (wb_tag == rd_tag_a) && entries[wb_tag].valid) begin
            rd_ready_a = 1'b1;
            rd_data_a  = wb_data;
        end
        if (wb_valid && (wb_tag == rd_tag_b) && entries[wb_tag].valid) begin
            rd_ready_b = 1'b1;
            rd_data_b  = wb_data;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Reorder buffer bench: directed scenarios plus random traffic against an in-order queue model.
module tb_reorder_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [2:0]  alloc_dest;
    logic        alloc_ready;
    logic [2:0]  alloc_tag;
    logic        wb_valid;
    logic [2:0]  wb_tag;
    logic [15:0] wb_data;
    logic        wb_exception;
    logic [2:0]  rd_tag_a;
    logic [2:0]  rd_tag_b;
    logic        rd_ready_a;
    logic        rd_ready_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        commit_valid;
    logic        commit_ready;
    logic [2:0]  commit_dest;
    logic [15:0] commit_data;
    logic        commit_exception;
    logic        flush;
    logic [3:0]  count;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk              (clk),
        .reset            (reset),
        .alloc_valid      (alloc_valid),
        .alloc_dest       (alloc_dest),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .wb_valid         (wb_valid),
        .wb_tag           (wb_tag),
        .wb_data          (wb_data),
        .wb_exception     (wb_exception),
        .rd_tag_a         (rd_tag_a),
        .rd_tag_b         (rd_tag_b),
        .rd_ready_a       (rd_ready_a),
        .rd_ready_b       (rd_ready_b),
        .rd_data_a        (rd_data_a),
        .rd_data_b        (rd_data_b),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_dest      (commit_dest),
        .commit_data      (commit_data),
        .commit_exception (commit_exception),
        .flush            (flush),
        .count            (count)
    );

    // Model: in-flight instructions in program order, each remembering its tag.
    typedef struct {
        int tag;
        int dest;
        bit done;
        bit exc;
        int data;
    } rec_t;

    rec_t q[$];
    int   next_tag;
    int   assertions;
    int   failures;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int findTag(input int t);
        foreach (q[i]) begin
            if (q[i].tag == t) return i;
        end
        return -1;
    endfunction

    task automatic expectRead(input int t, output bit rdy, output int d);
        int idx;
        idx = findTag(t);
        rdy = (idx >= 0) && q[idx].done;
        d   = rdy ? q[idx].data : 0;
        if (wb_valid && (int'(wb_tag) == t) && (idx >= 0)) begin
            rdy = 1'b1;
            d   = int'(wb_data);
        end
    endtask

    task automatic checkModel();
        bit cv;
        bit ra;
        bit rb;
        int da;
        int db;
        cv = (q.size() > 0) && q[0].done;
        checkOutput("count", 32'(count), q.size());
        checkOutput("alloc_ready", 32'(alloc_ready), 32'(q.size() < DEPTH));
        checkOutput("alloc_tag", 32'(alloc_tag), next_tag);
        checkOutput("commit_valid", 32'(commit_valid), 32'(cv));
        if (cv) begin
            checkOutput("commit_dest", 32'(commit_dest), q[0].dest);
            checkOutput("commit_data", 32'(commit_data), q[0].data);
            checkOutput("commit_exception", 32'(commit_exception), 32'(q[0].exc));
        end
        expectRead(int'(rd_tag_a), ra, da);
        expectRead(int'(rd_tag_b), rb, db);
        checkOutput("rd_ready_a", 32'(rd_ready_a), 32'(ra));
        checkOutput("rd_ready_b", 32'(rd_ready_b), 32'(rb));
        if (ra) checkOutput("rd_data_a", 32'(rd_data_a), da);
        if (rb) checkOutput("rd_data_b", 32'(rd_data_b), db);
    endtask

    task automatic updateModel();
        bit   cv;
        bit   do_commit;
        bit   squash;
        bit   do_alloc;
        int   idx;
        rec_t r;
        if (flush) begin
            q.delete();
            next_tag = 0;
            return;
        end
        cv        = (q.size() > 0) && q[0].done;
        do_commit = cv && commit_ready;
        squash    = do_commit && q[0].exc;
        do_alloc  = alloc_valid && (q.size() < DEPTH);
        if (wb_valid) begin
            idx = findTag(int'(wb_tag));
            if (idx >= 0) begin
                q[idx].done = 1'b1;
                q[idx].data = int'(wb_data);
                q[idx].exc  = wb_exception;
            end
        end
        if (do_commit) q.delete(0);
        if (squash) begin
            q.delete();
            next_tag = 0;
        end else if (do_alloc) begin
            r.tag  = next_tag;
            r.dest = int'(alloc_dest);
            r.done = 1'b0;
            r.exc  = 1'b0;
            r.data = 0;
            q.push_back(r);
            next_tag = (next_tag + 1) % DEPTH;
        end
    endtask

    task automatic applyStimulus(input bit av, input int ad, input bit wv, input int wt, input int wd,
                                 input bit we, input bit cr, input bit fl, input int ra, input int rb);
        alloc_valid  = av;
        alloc_dest   = 3'(ad);
        wb_valid     = wv;
        wb_tag       = 3'(wt);
        wb_data      = 16'(wd);
        wb_exception = we;
        commit_ready = cr;
        flush        = fl;
        rd_tag_a     = 3'(ra);
        rd_tag_b     = 3'(rb);
    endtask

    // Called at a falling edge with inputs applied: check, advance model, move to next falling edge.
    task automatic stepCycle();
        #1;
        checkModel();
        updateModel();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        next_tag   = 0;
        reset      = 1'b0;
        idle();

        @(negedge clk);
        #1;
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_alloc_ready", 32'(alloc_ready), 1);
        checkOutput("reset_alloc_tag", 32'(alloc_tag), 0);
        checkOutput("reset_commit_valid", 32'(commit_valid), 0);
        checkOutput("reset_commit_exception", 32'(commit_exception), 0);
        checkOutput("reset_rd_ready_a", 32'(rd_ready_a), 0);
        @(negedge clk);
        reset = 1'b1;

        // Fill all eight slots, then a ninth request must bounce.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, i, 0, 0, 0, 0, 0, 0, i, 0);
            stepCycle();
        end
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("full_alloc_ready", 32'(alloc_ready), 0);
        checkOutput("full_count", 32'(count), 8);
        stepCycle();

        // Out-of-order writeback: tag 2 completes first but cannot retire.
        applyStimulus(0, 0, 1, 2, 16'h00AA, 0, 1, 0, 2, 2);
        stepCycle();
        #1;
        checkOutput("head_not_done", 32'(commit_valid), 0);
        applyStimulus(0, 0, 1, 0, 16'h0055, 0, 1, 0, 0, 2);
        stepCycle();
        #1;
        checkOutput("head_commit_valid", 32'(commit_valid), 1);
        checkOutput("head_commit_data", 32'(commit_data), 32'h0055);
        checkOutput("head_commit_dest", 32'(commit_dest), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
        stepCycle();
        #1;
        checkOutput("tag1_blocks_tag2", 32'(commit_valid), 0);

        // Bypass of a writeback landing this very cycle.
        applyStimulus(0, 0, 1, 3, 16'h1234, 0, 0, 0, 3, 2);
        #1;
        checkOutput("fwd_ready_a", 32'(rd_ready_a), 1);
        checkOutput("fwd_data_a", 32'(rd_data_a), 32'h1234);
        stepCycle();

        // Flush wins over a simultaneous allocation.
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        stepCycle();

        // Full buffer commits while refusing a same-cycle allocation.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 7 - i, 0, 0, 0, 0, 0, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 1, 0, 16'h0BEE, 0, 0, 0, 0, 1);
        stepCycle();
        applyStimulus(1, 3, 0, 0, 0, 0, 1, 0, 0, 1);
        #1;
        checkOutput("full_commit_valid", 32'(commit_valid), 1);
        checkOutput("full_commit_refuse", 32'(alloc_ready), 0);
        stepCycle();
        #1;
        checkOutput("after_commit_count", 32'(count), 7);
        checkOutput("after_commit_tag", 32'(alloc_tag), 0);
        applyStimulus(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle();
        #1;
        checkOutput("refill_count", 32'(count), 8);

        // Exception at the head squashes the whole buffer on retirement.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, i + 2, 0, 0, 0, 0, 0, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 1, 0, 16'hDEAD, 1, 0, 0, 0, 1);
        stepCycle();
        applyStimulus(1, 6, 1, 1, 16'h0101, 0, 1, 0, 0, 1);
        #1;
        checkOutput("exc_commit_exception", 32'(commit_exception), 1);
        stepCycle();
        #1;
        checkOutput("exc_count", 32'(count), 0);
        checkOutput("exc_alloc_tag", 32'(alloc_tag), 0);
        checkOutput("exc_commit_valid", 32'(commit_valid), 0);

        // Reset pulsed mid-operation with a completed head pending.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 0, 0);
            stepCycle();
        end
        applyStimulus(0, 0, 1, 0, 16'h7777, 0, 0, 0, 0, 0);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_count", 32'(count), 0);
        checkOutput("midreset_commit_valid", 32'(commit_valid), 0);
        q.delete();
        next_tag = 0;
        @(negedge clk);
        reset = 1'b1;
        stepCycle();
        #1;
        checkOutput("postreset_alloc_tag", 32'(alloc_tag), 0);

        // Random traffic; writebacks mostly target live tags.
        for (int n = 0; n < 600; n++) begin
            int wt;
            wt = int'($urandom_range(7));
            if ((q.size() > 0) && ($urandom_range(3) != 0)) begin
                wt = q[$urandom_range(q.size() - 1)].tag;
            end
            applyStimulus($urandom_range(9) < 7, int'($urandom_range(7)),
                          $urandom_range(1) == 1, wt, int'($urandom_range(16'hFFFF)),
                          $urandom_range(11) == 0, $urandom_range(4) < 3,
                          $urandom_range(39) == 0,
                          ($urandom_range(1) == 1) ? wt : int'($urandom_range(7)),
                          int'($urandom_range(7)));
            stepCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
